// File: rtl/calc_disp_pkg.sv
// Shared types and glyph constants for the calculator result display.
// Optional error blink is enabled by defining CALC_DISP_BLINK_EN.
package calc_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    ERR  = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] l;
    logic [2:0] f;
  } result_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module seg7_decode (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    // NOTE: a full case with a default keeps this purely combinational; a
    // missing branch here would infer a latch.
    unique case (hex_i)
      4'h0:    seg_o = 7'b1000000;
      4'h1:    seg_o = 7'b1111001;
      4'h2:    seg_o = 7'b0100100;
      4'h3:    seg_o = 7'b0110000;
      4'h4:    seg_o = 7'b0011001;
      4'h5:    seg_o = 7'b0010010;
      4'h6:    seg_o = 7'b0000010;
      4'h7:    seg_o = 7'b1111000;
      4'h8:    seg_o = 7'b0000000;
      4'h9:    seg_o = 7'b0010000;
      4'hA:    seg_o = 7'b0001000;
      4'hB:    seg_o = 7'b0000011;
      4'hC:    seg_o = 7'b1000110;
      4'hD:    seg_o = 7'b0100001;
      4'hE:    seg_o = 7'b0000110;
      default: seg_o = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/calc_result_display.sv
// Captures the calculator result on each Done rising edge and scans it onto a
// 4-digit active-low display. Define CALC_DISP_BLINK_EN to blink the error message.
module calc_result_display
  import calc_disp_pkg::*;
#(
  parameter int REFRESH_CNT = 50000,
  parameter int BLINK_BITS  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Done,
  input  logic       div_Err,
  input  logic [3:0] H_Out,
  input  logic [3:0] L_Out,
  input  logic [2:0] F_Q,
  input  logic       clr,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       valid
);

  localparam int CW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;

  if (REFRESH_CNT < 2 || BLINK_BITS < 1) begin : g_bad_cfg
    $error("calc_result_display: REFRESH_CNT must be >= 2 and BLINK_BITS >= 1");
  end

  state_e        state_q, state_d;
  result_t       res_q;
  logic [CW-1:0] ref_cnt_q;
  logic [1:0]    idx_q;
  logic          done_q, armed_q, valid_q;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d, hex_seg;
  logic [3:0]    nib;
  logic          cap, term;
`ifdef CALC_DISP_BLINK_EN
  logic [BLINK_BITS-1:0] frame_q;
`endif

  // armed_q masks the first cycle after reset so a Done held across reset is not an edge.
  assign cap  = Done & ~done_q & armed_q;
  assign term = (ref_cnt_q == CW'(REFRESH_CNT - 1));

  always_comb begin
    state_d = state_q;
    if (cap)      state_d = div_Err ? ERR : SHOW;
    else if (clr) state_d = IDLE;
  end

  always_comb begin
    unique case (idx_q)
      2'd0:    nib = res_q.l;
      2'd1:    nib = res_q.h;
      2'd3:    nib = {1'b0, res_q.f};
      default: nib = 4'h0;
    endcase
  end

  seg7_decode u_dec (
    .hex_i (nib),
    .seg_o (hex_seg)
  );

  always_comb begin
    seg_d = SEG_DASH;
    unique case (state_q)
      SHOW:    seg_d = (idx_q == 2'd2) ? SEG_BLANK : hex_seg;
      ERR: begin
        unique case (idx_q)
          2'd0:    seg_d = SEG_BLANK;
          2'd3:    seg_d = SEG_E;
          default: seg_d = SEG_R;
        endcase
      end
      default: seg_d = SEG_DASH;
    endcase

    an_d = ~(4'b0001 << idx_q);
`ifdef CALC_DISP_BLINK_EN
    if (state_q == ERR && frame_q[BLINK_BITS-1]) an_d = 4'b1111;
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: every register here uses non-blocking assignment so all of them
    // update from the same pre-edge values.
    if (!rst) begin
      state_q   <= IDLE;
      res_q     <= '0;
      ref_cnt_q <= '0;
      idx_q     <= 2'd0;
      done_q    <= 1'b0;
      armed_q   <= 1'b0;
      valid_q   <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= SEG_BLANK;
`ifdef CALC_DISP_BLINK_EN
      frame_q   <= '0;
`endif
    end else begin
      done_q  <= Done;
      armed_q <= 1'b1;
      state_q <= state_d;
      valid_q <= (state_d != IDLE);
      if (cap) res_q <= '{h: H_Out, l: L_Out, f: F_Q};

      if (term) begin
        ref_cnt_q <= '0;
        idx_q     <= idx_q + 2'd1;
      end else begin
        ref_cnt_q <= ref_cnt_q + CW'(1);
      end

      an_q  <= an_d;
      seg_q <= seg_d;
`ifdef CALC_DISP_BLINK_EN
      if (cap)                         frame_q <= '0;
      else if (term && idx_q == 2'd3)  frame_q <= frame_q + 1'b1;
`endif
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = 1'b1;
  assign valid = valid_q;

endmodule

// File: tb/tb_calc_result_display.sv
// Self-checking bench for calc_result_display: directed vectors, corner sequences
// and randomized traffic against a time-based reference model.
module tb_calc_result_display;

  localparam int R  = 4;
  localparam int BB = 2;

  logic       clk, rst, Done, div_Err, clr;
  logic [3:0] H_Out, L_Out;
  logic [2:0] F_Q;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, valid;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  calc_result_display #(.REFRESH_CNT(R), .BLINK_BITS(BB)) dut (
    .clk(clk), .rst(rst), .Done(Done), .div_Err(div_Err),
    .H_Out(H_Out), .L_Out(L_Out), .F_Q(F_Q), .clr(clr),
    .an(an), .seg(seg), .dp(dp), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] hexseg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // mode: 0 idle, 1 showing a result, 2 showing the error message
  function automatic logic [6:0] glyph(input int mode, input int d,
                                       input logic [3:0] h, input logic [3:0] l,
                                       input logic [2:0] f);
    if (mode == 0) return 7'b0111111;
    if (mode == 2) begin
      if (d == 0) return 7'b1111111;
      if (d == 3) return 7'b0000110;
      return 7'b0101111;
    end
    if (d == 0) return hexseg(l);
    if (d == 1) return hexseg(h);
    if (d == 2) return 7'b1111111;
    return hexseg({1'b0, f});
  endfunction

  // Reference model: digit shown at the k-th active edge is ((k-1)/R) mod 4.
  int         k, m_mode, m_fc, d;
  logic       m_first, m_prev, m_cap;
  logic [3:0] m_h, m_l, m_an;
  logic [2:0] m_f;
  logic [6:0] m_seg;
  logic       m_valid;

  always @(posedge clk) begin
    if (!rst) begin
      k = 0; m_mode = 0; m_fc = 0; m_first = 1'b1; m_prev = 1'b0;
      m_h = 4'h0; m_l = 4'h0; m_f = 3'h0;
      m_an = 4'b1111; m_seg = 7'b1111111; m_valid = 1'b0;
    end else begin
      k++;
      d = ((k - 1) / R) % 4;
      m_an  = ~(4'b0001 << d);
      m_seg = glyph(m_mode, d, m_h, m_l, m_f);
`ifdef CALC_DISP_BLINK_EN
      if (m_mode == 2 && m_fc >= (1 << (BB - 1))) m_an = 4'b1111;
`endif
      m_cap   = Done && !m_prev && !m_first;
      m_first = 1'b0;
      m_prev  = Done;
      if (m_cap) begin
        m_mode = div_Err ? 2 : 1;
        m_h = H_Out; m_l = L_Out; m_f = F_Q;
        m_fc = 0;
      end else begin
        if (clr) m_mode = 0;
        if (k % (4 * R) == 0) m_fc = (m_fc + 1) % (1 << BB);
      end
      m_valid = (m_mode != 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_an", 32'(an), 32'(m_an));
      check("model_seg", 32'(seg), 32'(m_seg));
      check("model_valid", 32'(valid), 32'(m_valid));
      check("model_dp", 32'(dp), 32'(1'b1));
    end
  end

  typedef struct {
    logic       derr;
    logic [3:0] h, l;
    logic [2:0] f;
    logic [6:0] s0, s1, s2, s3;
  } vec_t;

  vec_t vecs[4];

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic collect(output logic [3:0][6:0] g);
    g = 'x;
    for (int i = 0; i < 4 * R; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: g[0] = seg;
        4'b1101: g[1] = seg;
        4'b1011: g[2] = seg;
        4'b0111: g[3] = seg;
        default: ;
      endcase
    end
  endtask

  logic [3:0][6:0] got;
  logic [3:0] an_seq[4];

  initial begin
    vecs[0] = '{1'b0, 4'h1, 4'hA, 3'd3, 7'b0001000, 7'b1111001, 7'b1111111, 7'b0110000};
    vecs[1] = '{1'b1, 4'h7, 4'h2, 3'd5, 7'b1111111, 7'b0101111, 7'b0101111, 7'b0000110};
    vecs[2] = '{1'b0, 4'hF, 4'h0, 3'd7, 7'b1000000, 7'b0001110, 7'b1111111, 7'b1111000};
    vecs[3] = '{1'b0, 4'h8, 4'hB, 3'd0, 7'b0000011, 7'b0000000, 7'b1111111, 7'b1000000};
    an_seq[0] = 4'b1110; an_seq[1] = 4'b1101; an_seq[2] = 4'b1011; an_seq[3] = 4'b0111;

    rst = 1'b0; Done = 1'b0; div_Err = 1'b0; clr = 1'b0;
    H_Out = 4'h0; L_Out = 4'h0; F_Q = 3'd0;
    chk_en = 1'b1;

    // Reset hold and idle scan
    cycles(3);
    check("rst_an", 32'(an), 32'h0000000F);
    check("rst_seg", 32'(seg), 32'h0000007F);
    check("rst_valid", 32'(valid), 32'h0);
    rst = 1'b1;
    for (int dg = 0; dg < 4; dg++)
      for (int c = 0; c < R; c++) begin
        @(negedge clk);
        check("idle_an", 32'(an), 32'(an_seq[dg]));
        check("idle_seg", 32'(seg), 32'(7'b0111111));
      end

    // Directed capture vectors
    for (int v = 0; v < 4; v++) begin
      div_Err = vecs[v].derr; H_Out = vecs[v].h; L_Out = vecs[v].l; F_Q = vecs[v].f;
      Done = 1'b1;
      @(negedge clk);
      Done = 1'b0;
      check("vec_valid", 32'(valid), 32'h1);
      @(negedge clk);
      collect(got);
      check("vec_d0", 32'(got[0]), 32'(vecs[v].s0));
      check("vec_d1", 32'(got[1]), 32'(vecs[v].s1));
      check("vec_d2", 32'(got[2]), 32'(vecs[v].s2));
      check("vec_d3", 32'(got[3]), 32'(vecs[v].s3));
    end

    // Capture and clear in the same cycle: capture wins
    div_Err = 1'b0; H_Out = 4'h5; L_Out = 4'h6; F_Q = 3'd2;
    Done = 1'b1; clr = 1'b1;
    @(negedge clk);
    Done = 1'b0; clr = 1'b0;
    check("capclr_valid", 32'(valid), 32'h1);
    collect(got);
    check("capclr_d0", 32'(got[0]), 32'(7'b0000010));
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_valid", 32'(valid), 32'h0);
    @(negedge clk);
    check("clr_seg", 32'(seg), 32'(7'b0111111));

    // Done held high: only the first-cycle values are taken
    H_Out = 4'h2; L_Out = 4'h3; F_Q = 3'd1; Done = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      H_Out = 4'($urandom); L_Out = 4'($urandom);
    end
    collect(got);
    check("held_d0", 32'(got[0]), 32'(7'b0110000));
    check("held_d1", 32'(got[1]), 32'(7'b0100100));
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cycles(2 * R);
    check("rsthold_valid", 32'(valid), 32'h0);
    check("rsthold_seg", 32'(seg), 32'(7'b0111111));
    Done = 1'b0;
    @(negedge clk);

    // Error shown steadily when the blink feature is absent
    div_Err = 1'b1; Done = 1'b1;
    @(negedge clk);
    Done = 1'b0;
    @(negedge clk);
`ifndef CALC_DISP_BLINK_EN
    for (int i = 0; i < 16 * R; i++) begin
      @(negedge clk);
      check("err_steady", 32'(an == 4'b1111), 32'h0);
    end
`else
    cycles(16 * R);
`endif

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) Done = ~Done;
      clr     = ($urandom_range(0, 15) == 0);
      div_Err = ($urandom_range(0, 3) == 0);
      H_Out   = 4'($urandom);
      L_Out   = 4'($urandom);
      F_Q     = 3'($urandom);
      rst     = ($urandom_range(0, 299) != 0);
    end
    rst = 1'b1; clr = 1'b0;
    cycles(4);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_result_display.md
# calc_result_display

Downstream display stage for the full calculator. Captures the 8-bit result (H_Out:L_Out), the latched opcode and the divide-error flag on each new Done, then drives a 4-digit, time-multiplexed, active-low seven-segment display. It sits between the calculator top level and the board display pins and holds the last result until cleared or overwritten.

## Interface
- REFRESH_CNT, 50000: clock cycles each digit stays lit; minimum 2.
- BLINK_BITS, 6: scan-frame counter width for the error blink (used only with the blink macro).
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- Done  in  1  calculator done level; only its rising edge is used.
- div_Err  in  1  divide-error flag, sampled with Done.
- H_Out  in  4  result high nibble.
- L_Out  in  4  result low nibble.
- F_Q  in  3  latched opcode.
- clr  in  1  synchronous clear back to the idle display.
- an  out  4  digit anodes, active-low, one-hot-low when lit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; always 1 (off).
- valid  out  1  high while a captured result or error is being shown.

## Operation
- Edge detect: done_q <= Done each cycle. cap = Done & ~done_q.
- States:
  - IDLE: shows "----".
  - SHOW: digit3 = hex(F_Q zero-extended), digit2 = blank, digit1 = hex(H), digit0 = hex(L).
  - ERR: shows "Err " with digit3 = E, digit2 = r, digit1 = r, digit0 = blank.
- Transitions:
  - On cap, capture H, L and F_Q into registers. Go to ERR if div_Err = 1, else SHOW. This applies from any state, so a new result overwrites the old one.
  - On clr with no cap, go to IDLE.
  - cap and clr in the same cycle: cap wins.
- valid = (state != IDLE), registered.
- Scan:
  - ref_cnt counts 0..REFRESH_CNT-1. At the terminal count it wraps to 0 and idx advances 0→1→2→3→0.
  - idx wraps from 3 to 0; each wrap to 0 ends one scan frame.
- Segment codes (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - '-'=0111111, 'r'=0101111, blank=1111111.
- Reset (rst = 0 at a clock edge): state = IDLE, ref_cnt = 0, idx = 0, done_q = 0, captured registers = 0, an = 1111, seg = 1111111, dp = 1, valid = 0.
- Reset mid-scan or mid-display aborts everything immediately. A Done that is still high after reset is not a new edge, because done_q reloads from Done on the first active cycle.

## Timing
- an and seg are registered from the current idx, state and captured data, so they lag an idx change by 1 cycle.
- First lit digit (digit0, an = 1110) appears on the 1st edge after rst deasserts.
- Capture happens at the edge where cap = 1. valid and the state change are visible after that edge. New data reaches the pins 1 cycle after the state change, on whichever digit is currently selected.
- Each digit is lit for exactly REFRESH_CNT cycles. One frame = 4·REFRESH_CNT cycles.

## Configuration
- CALC_DISP_BLINK_EN defined:
  - A BLINK_BITS-wide frame counter increments at each frame end.
  - In ERR, an is forced to 1111 while the counter MSB = 1. SHOW and IDLE are unaffected.
  - The counter resets to 0 on rst and on every cap.
- CALC_DISP_BLINK_EN undefined: no frame counter is present and ERR is shown steadily.

## Structure
- Package calc_disp_pkg holds:
  - the state enum (IDLE, SHOW, ERR);
  - segment constants SEG_DASH, SEG_BLANK, SEG_E, SEG_R.
- Sub-module seg7_decode: combinational, 4-bit hex to 7-bit active-low segments. The top level instantiates it once on the selected nibble, and muxes in the special glyphs.

## Test plan
- Reset, REFRESH_CNT=4:
  - hold rst=0 for 3 cycles → an=1111, seg=1111111, valid=0;
  - release → an steps 1110, 1101, 1011, 0111 every 4 cycles, seg=0111111 on every digit.
- Done rising with H=1, L=A, F_Q=3, div_Err=0 → valid=1 next cycle; over one frame seg shows 0001000 (d0), 1111001 (d1), 1111111 (d2), 0110000 (d3).
- Done rising with div_Err=1 → frame shows blank (d0), 0101111 (d1), 0101111 (d2), 0000110 (d3); valid=1.
- Same-cycle stimuli:
  - clr=1 in the same cycle as a Done rising edge → capture taken, state SHOW;
  - clr alone later → "----" and valid=0 next cycle.
- Done held high for 20 cycles with H/L changing → only the first-cycle values are displayed; a rst pulse while Done stays high → IDLE, no recapture.
- With CALC_DISP_BLINK_EN, BLINK_BITS=2, in ERR → an=1111 for 2 frames, lit for 2 frames, repeating. Without the macro → an never all-1 in ERR after the first lit cycle.
